// File: rtl/matrix_pkg.sv
// Shared types and widths for the 2x2 matrix-multiply job scheduler.
// Core opcodes, scheduler states and operand/result widths.
package matrix_pkg;

  localparam int indata_size = 8;
  localparam int OPND_W      = 32;
  localparam int Z_W         = 4 * indata_size;

  typedef enum logic [1:0] {
    OP_NOP    = 2'd0,
    OP_LOAD_A = 2'd1,
    OP_LOAD_B = 2'd2,
    OP_START  = 2'd3
  } core_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_START,
    S_WAIT,
    S_CAPTURE,
    S_RESP
  } sched_state_e;

endpackage

// File: rtl/mm_job_scheduler_if.sv
// Requester-side job/response bundle shared by all requesters.
// master = requesters, slave = scheduler.
interface mm_job_scheduler_if
  import matrix_pkg::*;
#(
  parameter int N_REQ = 2
) ();

  logic [N_REQ-1:0]             req_valid;
  logic [N_REQ-1:0]             req_ready;
  logic [N_REQ-1:0][OPND_W-1:0] req_a;
  logic [N_REQ-1:0][OPND_W-1:0] req_b;
  logic [N_REQ-1:0]             rsp_valid;
  logic [N_REQ-1:0]             rsp_ready;
  logic [4*Z_W-1:0]             rsp_z;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_z
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_z
  );

endinterface

// File: rtl/mm_job_scheduler_rr_arbiter.sv
// Round-robin arbiter: searches from last grant + 1.
// Pointer moves only on advance.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int W = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0] ptr_q, ptr_d;
  logic [W:0]   sum;
  logic [W-1:0] idx;
  logic         found;

  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 1; i <= N; i++) begin
      sum = {1'b0, ptr_q} + (W+1)'(i);
      if (sum >= (W+1)'(N)) sum = sum - (W+1)'(N);
      idx = sum[W-1:0];
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        if (advance) ptr_d = idx;
      end
    end
  end

  // Reset to N-1 so requester 0 is searched first.
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= W'(N - 1);
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mm_job_scheduler.sv
// Arbitrates 2x2 matmul jobs onto one shared core and
// sequences LOAD_A/LOAD_B/START, waits, captures and responds.
module mm_job_scheduler
  import matrix_pkg::*;
#(
  parameter int N_REQ        = 2,
  parameter int CORE_LATENCY = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  mm_job_scheduler_if.slave     bus,
  output logic [OPND_W-1:0]     core_cntrl,
  output logic [OPND_W-1:0]     core_fetch,
  input  logic signed [Z_W-1:0] core_z11,
  input  logic signed [Z_W-1:0] core_z12,
  input  logic signed [Z_W-1:0] core_z21,
  input  logic signed [Z_W-1:0] core_z22,
  output logic                  busy
);

  localparam int OW = $clog2(N_REQ);
  localparam int CW = $clog2(CORE_LATENCY + 1);

  sched_state_e        state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [OW-1:0]       own_q, own_d;
  logic [OPND_W-1:0]   a_q, a_d, b_q, b_d;
  logic [OPND_W-1:0]   cntrl_q, cntrl_d;
  logic [OPND_W-1:0]   fetch_q, fetch_d;
  logic [4*Z_W-1:0]    z_q, z_d;
  logic [N_REQ-1:0]    grant, arb_req;
  logic                idle, hs;
  core_op_e            op_d;

  assign idle    = (state_q == S_IDLE);
  assign arb_req = idle ? bus.req_valid : '0;
  assign hs      = |grant;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (arb_req),
    .advance (hs),
    .grant   (grant)
  );

  assign bus.req_ready = grant;
  assign bus.rsp_valid = (state_q == S_RESP)
                       ? ({{(N_REQ-1){1'b0}}, 1'b1} << own_q)
                       : '0;
  assign bus.rsp_z     = z_q;
  assign core_cntrl    = cntrl_q;
  assign core_fetch    = fetch_q;
  assign busy          = !idle;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE:    if (hs) state_d = S_LOAD_A;
      S_LOAD_A:  state_d = S_LOAD_B;
      S_LOAD_B:  state_d = S_START;
      S_START: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (cnt_q == CW'(CORE_LATENCY - 1)) state_d = S_CAPTURE;
        else cnt_d = cnt_q + 1'b1;
      end
      S_CAPTURE: state_d = S_RESP;
      S_RESP:    if (bus.rsp_ready[own_q]) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Command word is registered from the next state so it lines up
  // with the state it belongs to.
  always_comb begin
    own_d = own_q;
    a_d   = a_q;
    b_d   = b_q;
    z_d   = z_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        own_d = OW'(i);
        a_d   = bus.req_a[i];
        b_d   = bus.req_b[i];
      end
    end
    if (state_q == S_CAPTURE)
      z_d = {core_z22, core_z21, core_z12, core_z11};
    unique case (state_d)
      S_LOAD_A: op_d = OP_LOAD_A;
      S_LOAD_B: op_d = OP_LOAD_B;
      S_START:  op_d = OP_START;
      default:  op_d = OP_NOP;
    endcase
    cntrl_d = {{(OPND_W-2){1'b0}}, op_d};
    fetch_d = (op_d == OP_LOAD_A) ? a_d
            : (op_d == OP_LOAD_B) ? b_d
            : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      own_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      z_q     <= '0;
      cntrl_q <= '0;
      fetch_q <= '0;
    end else begin
      own_q   <= own_d;
      a_q     <= a_d;
      b_q     <= b_d;
      z_q     <= z_d;
      cntrl_q <= cntrl_d;
      fetch_q <= fetch_d;
    end
  end

endmodule
